// File: rtl/multicycle_ctrl_v2.sv
// multicycle_ctrl_v2: multicycle control unit for the RISC-V datapath.
// It adds request/ready handshakes with a bus timeout on both memories.
// Exceptions are precise: the EXC state drives EPC and the cause.
// It also has a halt state and load/store size decode.
// Every datapath strobe is a Moore output decoded from the state register.
module multicycle_ctrl_v2 #(
    parameter int TIMEOUT  = 15,
    parameter bit OVF_TRAP = 1'b1
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic [31:0] instruction,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        overflow,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        LoadIR,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        LoadRegA,
    output logic        LoadRegB,
    output logic        LoadALUOut,
    output logic        LoadMDR,
    output logic        WriteReg,
    output logic        DMemWrite,
    output logic        EPCWrite,
    output logic [1:0]  PCSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ALUFunct,
    output logic [2:0]  MemToReg,
    output logic [1:0]  BranchOp,
    output logic [1:0]  ShiftControl,
    output logic [1:0]  tam,
    output logic [1:0]  exc_cause,
    output logic        halted,
    output logic [4:0]  state
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'd0;
    localparam logic [1:0] CAUSE_OVF     = 2'd1;
    localparam logic [1:0] CAUSE_BUS     = 2'd2;

    typedef enum logic [4:0] {
        S_FETCH     = 5'd0,
        S_IR_PC     = 5'd1,
        S_DECODE    = 5'd2,
        S_ADDR      = 5'd3,
        S_MEM_RD    = 5'd4,
        S_MEM_LATCH = 5'd5,
        S_LD_WB     = 5'd6,
        S_MEM_WR    = 5'd7,
        S_EXEC_R    = 5'd8,
        S_EXEC_I    = 5'd9,
        S_ALU_WB    = 5'd10,
        S_LUI_WB    = 5'd11,
        S_SHIFT_WB  = 5'd12,
        S_SLT_WB    = 5'd13,
        S_BRANCH    = 5'd14,
        S_JAL_LINK  = 5'd15,
        S_JALR_ADDR = 5'd16,
        S_JUMP      = 5'd17,
        S_EXC       = 5'd18,
        S_HALT      = 5'd19
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       cause_q, cause_d;
    logic [1:0]       exc_code;

    // Instruction fields; IR is stable from IR_PC onward, so decode straight from it
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic       unused_rs_fields;

    assign opcode           = instruction[6:0];
    assign funct3           = instruction[14:12];
    assign funct7           = instruction[31:25];
    assign rd               = instruction[11:7];
    assign unused_rs_fields = ^instruction[24:15];

    // Only add and sub in EXEC_R can trap on overflow; and never does
    logic r_is_addsub;
    assign r_is_addsub = (funct3 != 3'b111);

    // The memory that the current wait state is talking to
    logic in_wait;
    logic wait_ready;
    assign in_wait    = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    assign wait_ready = (state_q == S_FETCH) ? imem_ready : dmem_ready;

    // Opcode dispatch out of DECODE; anything not recognised is an illegal instruction
    function automatic state_t decode_next(input logic [31:0] ir);
        state_t     nxt;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [5:0] f6;
        op  = ir[6:0];
        f3  = ir[14:12];
        f7  = ir[31:25];
        f6  = ir[31:26];
        nxt = S_EXC;
        case (op)
            OP_R: begin
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'b000, 3'b111: nxt = S_EXEC_R;
                        3'b010:         nxt = S_SLT_WB;
                        default:        nxt = S_EXC;
                    endcase
                end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                    nxt = S_EXEC_R;
                end
            end
            OP_I: begin
                if (ir[11:7] == 5'd0) begin
                    nxt = S_FETCH;
                end else begin
                    case (f3)
                        3'b000:  nxt = S_EXEC_I;
                        3'b010:  nxt = S_SLT_WB;
                        3'b001:  nxt = (f6 == 6'b000000) ? S_SHIFT_WB : S_EXC;
                        3'b101:  nxt = (f6 == 6'b000000 || f6 == 6'b010000) ? S_SHIFT_WB : S_EXC;
                        default: nxt = S_EXC;
                    endcase
                end
            end
            OP_LOAD, OP_STORE: nxt = S_ADDR;
            OP_LUI:            nxt = S_LUI_WB;
            OP_BRANCH:         nxt = S_BRANCH;
            OP_JALR: begin
                case (f3)
                    3'b000:                 nxt = S_JAL_LINK;
                    3'b001, 3'b101, 3'b100: nxt = S_BRANCH;
                    default:                nxt = S_EXC;
                endcase
            end
            OP_JAL:    nxt = S_JAL_LINK;
            OP_SYSTEM: nxt = S_HALT;
            default:   nxt = S_EXC;
        endcase
        return nxt;
    endfunction

    // State, wait counter and cause register; asynchronous reset back to FETCH
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            cause_q <= CAUSE_ILLEGAL;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    // Next state, timeout counting and cause capture
    always_comb begin
        state_d  = state_q;
        exc_code = CAUSE_ILLEGAL;
        case (state_q)
            S_FETCH: begin
                if (imem_ready) begin
                    state_d = S_IR_PC;
                end else if (cnt_q == CNT_MAX) begin
                    state_d  = S_EXC;
                    exc_code = CAUSE_BUS;
                end
            end
            S_IR_PC:  state_d = S_DECODE;
            S_DECODE: state_d = decode_next(instruction);
            S_ADDR:   state_d = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (dmem_ready) begin
                    state_d = S_MEM_LATCH;
                end else if (cnt_q == CNT_MAX) begin
                    state_d  = S_EXC;
                    exc_code = CAUSE_BUS;
                end
            end
            S_MEM_LATCH: state_d = S_LD_WB;
            S_LD_WB:     state_d = S_FETCH;
            S_MEM_WR: begin
                if (dmem_ready) begin
                    state_d = S_FETCH;
                end else if (cnt_q == CNT_MAX) begin
                    state_d  = S_EXC;
                    exc_code = CAUSE_BUS;
                end
            end
            S_EXEC_R: begin
                if (OVF_TRAP && overflow && r_is_addsub) begin
                    state_d  = S_EXC;
                    exc_code = CAUSE_OVF;
                end else begin
                    state_d = S_ALU_WB;
                end
            end
            S_EXEC_I: begin
                if (OVF_TRAP && overflow) begin
                    state_d  = S_EXC;
                    exc_code = CAUSE_OVF;
                end else begin
                    state_d = S_ALU_WB;
                end
            end
            S_ALU_WB, S_LUI_WB, S_SHIFT_WB, S_SLT_WB, S_BRANCH: state_d = S_FETCH;
            S_JAL_LINK:  state_d = (opcode == OP_JALR) ? S_JALR_ADDR : S_JUMP;
            S_JALR_ADDR: state_d = S_JUMP;
            S_JUMP:      state_d = S_FETCH;
            S_EXC:       state_d = S_FETCH;
            S_HALT:      state_d = S_HALT;
            default:     state_d = S_FETCH;
        endcase

        // Cause is captured only on the way into EXC and held otherwise
        cause_d = cause_q;
        if (state_d == S_EXC && state_q != S_EXC) begin
            cause_d = exc_code;
        end

        // Counter restarts on every state change, so each wait state starts from zero
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (in_wait && !wait_ready) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Moore strobes decoded from the current state
    always_comb begin
        imem_req     = 1'b0;
        dmem_req     = 1'b0;
        LoadIR       = 1'b0;
        PCWrite      = 1'b0;
        PCWriteCond  = 1'b0;
        LoadRegA     = 1'b0;
        LoadRegB     = 1'b0;
        LoadALUOut   = 1'b0;
        LoadMDR      = 1'b0;
        WriteReg     = 1'b0;
        DMemWrite    = 1'b0;
        EPCWrite     = 1'b0;
        PCSrc        = 2'b00;
        ALUSrcA      = 1'b0;
        ALUSrcB      = 2'b00;
        ALUFunct     = 3'b000;
        MemToReg     = 3'd0;
        BranchOp     = 2'b00;
        ShiftControl = 2'b00;
        tam          = 2'b00;
        exc_cause    = 2'b00;
        halted       = 1'b0;
        case (state_q)
            S_FETCH: imem_req = 1'b1;
            S_IR_PC: begin
                LoadIR   = 1'b1;
                PCWrite  = 1'b1;
                PCSrc    = 2'd0;
                ALUSrcB  = 2'b01;
                ALUFunct = 3'b001;
            end
            S_DECODE: begin
                LoadRegA   = 1'b1;
                LoadRegB   = 1'b1;
                LoadALUOut = 1'b1;
                ALUSrcB    = 2'b11;
                ALUFunct   = 3'b001;
            end
            S_ADDR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUFunct   = 3'b001;
                LoadALUOut = 1'b1;
                tam        = funct3[1:0];
            end
            S_MEM_RD: begin
                dmem_req = 1'b1;
                tam      = funct3[1:0];
            end
            S_MEM_LATCH: begin
                LoadMDR = 1'b1;
                tam     = funct3[1:0];
            end
            S_LD_WB: begin
                WriteReg = 1'b1;
                MemToReg = 3'd1;
                tam      = funct3[1:0];
            end
            S_MEM_WR: begin
                dmem_req  = 1'b1;
                DMemWrite = 1'b1;
                tam       = funct3[1:0];
            end
            S_EXEC_R: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b00;
                LoadALUOut = 1'b1;
                if (funct3 == 3'b111) begin
                    ALUFunct = 3'b011;
                end else if (funct7 == 7'b0100000) begin
                    ALUFunct = 3'b010;
                end else begin
                    ALUFunct = 3'b001;
                end
            end
            S_EXEC_I: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUFunct   = 3'b001;
                LoadALUOut = 1'b1;
            end
            S_ALU_WB: begin
                WriteReg = 1'b1;
                MemToReg = 3'd0;
            end
            S_LUI_WB: begin
                WriteReg = 1'b1;
                MemToReg = 3'd2;
            end
            S_SHIFT_WB: begin
                WriteReg = 1'b1;
                MemToReg = 3'd4;
                if (funct3 == 3'b001) begin
                    ShiftControl = 2'b00;
                end else if (instruction[30]) begin
                    ShiftControl = 2'b10;
                end else begin
                    ShiftControl = 2'b01;
                end
            end
            S_SLT_WB: begin
                WriteReg = 1'b1;
                MemToReg = 3'd5;
                ALUFunct = 3'b010;
                ALUSrcA  = 1'b1;
                ALUSrcB  = (opcode == OP_R) ? 2'b00 : 2'b10;
            end
            S_BRANCH: begin
                PCWriteCond = 1'b1;
                PCSrc       = 2'd1;
                ALUFunct    = 3'b010;
                ALUSrcA     = 1'b1;
                if (opcode == OP_BRANCH) begin
                    BranchOp = 2'b00;
                end else begin
                    case (funct3)
                        3'b001:  BranchOp = 2'b01;
                        3'b101:  BranchOp = 2'b10;
                        3'b100:  BranchOp = 2'b11;
                        default: BranchOp = 2'b00;
                    endcase
                end
            end
            S_JAL_LINK: begin
                WriteReg = 1'b1;
                MemToReg = 3'd3;
            end
            S_JALR_ADDR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUFunct   = 3'b001;
                LoadALUOut = 1'b1;
            end
            S_JUMP: begin
                PCWrite = 1'b1;
                PCSrc   = 2'd1;
            end
            S_EXC: begin
                EPCWrite  = 1'b1;
                PCWrite   = 1'b1;
                PCSrc     = 2'd2;
                exc_cause = cause_q;
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_v2.sv
// Directed bench for multicycle_ctrl_v2. Expectations are queued while stimulus is
// driven and popped/compared on the falling edge of the same cycle.
// dut_a: TIMEOUT=4, overflow traps. dut_b: default TIMEOUT, overflow ignored.
module tb_multicycle_ctrl_v2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        Reset;
    logic [31:0] instruction;
    logic        imem_ready, dmem_ready, overflow;

    logic       imem_req, dmem_req, LoadIR, PCWrite, PCWriteCond, LoadRegA, LoadRegB;
    logic       LoadALUOut, LoadMDR, WriteReg, DMemWrite, EPCWrite, ALUSrcA, halted;
    logic [1:0] PCSrc, ALUSrcB, BranchOp, ShiftControl, tam, exc_cause;
    logic [2:0] ALUFunct, MemToReg;
    logic [4:0] state;

    logic       imem_req_b, dmem_req_b, LoadIR_b, PCWrite_b, PCWriteCond_b, LoadRegA_b, LoadRegB_b;
    logic       LoadALUOut_b, LoadMDR_b, WriteReg_b, DMemWrite_b, EPCWrite_b, ALUSrcA_b, halted_b;
    logic [1:0] PCSrc_b, ALUSrcB_b, BranchOp_b, ShiftControl_b, tam_b, exc_cause_b;
    logic [2:0] ALUFunct_b, MemToReg_b;
    logic [4:0] state_b;

    multicycle_ctrl_v2 #(.TIMEOUT(4), .OVF_TRAP(1'b1)) dut_a (
        .clk(clk), .Reset(Reset), .instruction(instruction), .imem_ready(imem_ready),
        .dmem_ready(dmem_ready), .overflow(overflow), .imem_req(imem_req), .dmem_req(dmem_req),
        .LoadIR(LoadIR), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .LoadRegA(LoadRegA),
        .LoadRegB(LoadRegB), .LoadALUOut(LoadALUOut), .LoadMDR(LoadMDR), .WriteReg(WriteReg),
        .DMemWrite(DMemWrite), .EPCWrite(EPCWrite), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUFunct(ALUFunct), .MemToReg(MemToReg), .BranchOp(BranchOp),
        .ShiftControl(ShiftControl), .tam(tam), .exc_cause(exc_cause), .halted(halted),
        .state(state)
    );

    multicycle_ctrl_v2 #(.OVF_TRAP(1'b0)) dut_b (
        .clk(clk), .Reset(Reset), .instruction(instruction), .imem_ready(imem_ready),
        .dmem_ready(dmem_ready), .overflow(overflow), .imem_req(imem_req_b), .dmem_req(dmem_req_b),
        .LoadIR(LoadIR_b), .PCWrite(PCWrite_b), .PCWriteCond(PCWriteCond_b), .LoadRegA(LoadRegA_b),
        .LoadRegB(LoadRegB_b), .LoadALUOut(LoadALUOut_b), .LoadMDR(LoadMDR_b), .WriteReg(WriteReg_b),
        .DMemWrite(DMemWrite_b), .EPCWrite(EPCWrite_b), .PCSrc(PCSrc_b), .ALUSrcA(ALUSrcA_b),
        .ALUSrcB(ALUSrcB_b), .ALUFunct(ALUFunct_b), .MemToReg(MemToReg_b), .BranchOp(BranchOp_b),
        .ShiftControl(ShiftControl_b), .tam(tam_b), .exc_cause(exc_cause_b), .halted(halted_b),
        .state(state_b)
    );

    localparam int K_STATE    = 0;
    localparam int K_IMEMREQ  = 1;
    localparam int K_DMEMREQ  = 2;
    localparam int K_WRITEREG = 3;
    localparam int K_ALUFUNCT = 4;
    localparam int K_TAM      = 5;
    localparam int K_LOADMDR  = 6;
    localparam int K_CAUSE    = 7;
    localparam int K_EPCW     = 8;
    localparam int K_PCW      = 9;
    localparam int K_PCSRC    = 10;
    localparam int K_HALTED   = 11;
    localparam int K_MEMTOREG = 12;
    localparam int K_LDALUOUT = 13;
    localparam int K_DMEMWR   = 14;
    localparam int K_REST     = 15;
    localparam int K_STATE_B  = 16;
    localparam int K_WR_B     = 17;

    typedef struct {
        string       tag;
        int          kind;
        logic [31:0] expv;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    int add_st[5]  = '{0, 1, 2, 8, 10};
    int ld_st[10]  = '{0, 1, 2, 3, 4, 4, 4, 4, 5, 6};
    int ov_st_a[5] = '{0, 1, 2, 8, 18};
    int ov_st_b[5] = '{0, 1, 2, 8, 10};
    int jr_st[6]   = '{0, 1, 2, 15, 16, 17};
    int st_st[6]   = '{0, 1, 2, 3, 7, 7};

    function automatic logic [31:0] observe(input int kind);
        logic [31:0] v;
        case (kind)
            K_STATE:    v = 32'(state);
            K_IMEMREQ:  v = 32'(imem_req);
            K_DMEMREQ:  v = 32'(dmem_req);
            K_WRITEREG: v = 32'(WriteReg);
            K_ALUFUNCT: v = 32'(ALUFunct);
            K_TAM:      v = 32'(tam);
            K_LOADMDR:  v = 32'(LoadMDR);
            K_CAUSE:    v = 32'(exc_cause);
            K_EPCW:     v = 32'(EPCWrite);
            K_PCW:      v = 32'(PCWrite);
            K_PCSRC:    v = 32'(PCSrc);
            K_HALTED:   v = 32'(halted);
            K_MEMTOREG: v = 32'(MemToReg);
            K_LDALUOUT: v = 32'(LoadALUOut);
            K_DMEMWR:   v = 32'(DMemWrite);
            K_REST:     v = 32'({dmem_req, LoadIR, PCWrite, PCWriteCond, LoadRegA, LoadRegB,
                                 LoadALUOut, LoadMDR, WriteReg, DMemWrite, EPCWrite, PCSrc,
                                 ALUSrcA, ALUSrcB, ALUFunct, MemToReg, BranchOp, ShiftControl,
                                 tam, exc_cause, halted});
            K_STATE_B:  v = 32'(state_b);
            K_WR_B:     v = 32'(WriteReg_b);
            default:    v = 32'hDEAD_BEEF;
        endcase
        return v;
    endfunction

    task automatic expect_v(input string tag, input int kind, input logic [31:0] v);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.expv = v;
        sb.push_back(e);
    endtask

    // Compare everything queued for this cycle at the falling edge, then advance to just past the next rising edge
    task automatic cycle();
        @(negedge clk);
        while (sb.size() > 0) begin
            exp_t        e;
            logic [31:0] obs;
            e   = sb.pop_front();
            obs = observe(e.kind);
            checks++;
            assert (obs === e.expv) else begin
                errors++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.expv);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        Reset       = 1'b1;
        instruction = 32'h002081B3;
        imem_ready  = 1'b1;
        dmem_ready  = 1'b1;
        overflow    = 1'b0;
        #1;

        // Reset held two cycles: FETCH values only
        for (int i = 0; i < 2; i++) begin
            expect_v("rst_state", K_STATE, 0);
            expect_v("rst_imem_req", K_IMEMREQ, 1);
            expect_v("rst_other_outputs", K_REST, 0);
            expect_v("rst_state_b", K_STATE_B, 0);
            cycle();
        end
        Reset = 1'b0;

        // add x3,x1,x2 with zero wait states
        instruction = 32'h002081B3;
        for (int i = 0; i < 5; i++) begin
            expect_v("add_state", K_STATE, 32'(add_st[i]));
            expect_v("add_writereg", K_WRITEREG, (add_st[i] == 10) ? 32'd1 : 32'd0);
            if (add_st[i] == 8) expect_v("add_alufunct", K_ALUFUNCT, 32'd1);
            cycle();
        end

        // ld x5 (doubleword) with dmem_ready low for the first three MEM_RD cycles
        instruction = 32'h00003283;
        dmem_ready  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 7) dmem_ready = 1'b1;
            expect_v("ld_state", K_STATE, 32'(ld_st[i]));
            expect_v("ld_loadmdr", K_LOADMDR, (ld_st[i] == 5) ? 32'd1 : 32'd0);
            if (ld_st[i] == 4) begin
                expect_v("ld_dmem_req", K_DMEMREQ, 1);
                expect_v("ld_tam", K_TAM, 32'd3);
            end
            if (ld_st[i] == 5) expect_v("ld_dmem_req_drop", K_DMEMREQ, 0);
            cycle();
        end

        // Instruction memory never answers: bus timeout after TIMEOUT+1 cycles in FETCH
        imem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            expect_v("to_state", K_STATE, 0);
            expect_v("to_imem_req", K_IMEMREQ, 1);
            cycle();
        end
        imem_ready = 1'b1;
        expect_v("to_exc_state", K_STATE, 18);
        expect_v("to_exc_cause", K_CAUSE, 2);
        expect_v("to_epcwrite", K_EPCW, 1);
        expect_v("to_pcwrite", K_PCW, 1);
        expect_v("to_pcsrc", K_PCSRC, 2);
        cycle();
        expect_v("to_back_fetch", K_STATE, 0);
        cycle();

        // Asynchronous reset mid-instruction brings both units back together
        Reset = 1'b1;
        expect_v("rst2_state", K_STATE, 0);
        expect_v("rst2_state_b", K_STATE_B, 0);
        cycle();
        Reset = 1'b0;

        // sub with overflow: trap in dut_a, plain write-back in dut_b
        instruction = 32'h402081B3;
        overflow    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            expect_v("ovf_state", K_STATE, 32'(ov_st_a[i]));
            expect_v("ovf_state_b", K_STATE_B, 32'(ov_st_b[i]));
            if (i == 3) expect_v("ovf_alufunct_sub", K_ALUFUNCT, 32'd2);
            if (i == 4) begin
                expect_v("ovf_cause", K_CAUSE, 1);
                expect_v("ovf_no_writereg", K_WRITEREG, 0);
                expect_v("ovf_writereg_b", K_WR_B, 1);
            end
            cycle();
        end
        overflow = 1'b0;

        // Illegal opcode 0x7F: cause must reload to 0
        instruction = 32'h0000007F;
        for (int i = 0; i < 3; i++) begin
            expect_v("ill_state", K_STATE, 32'(i));
            cycle();
        end
        expect_v("ill_exc_state", K_STATE, 18);
        expect_v("ill_cause", K_CAUSE, 0);
        expect_v("ill_epcwrite", K_EPCW, 1);
        cycle();

        // Break: HALT is absorbing until Reset
        instruction = 32'h00100073;
        for (int i = 0; i < 3; i++) begin
            expect_v("brk_state", K_STATE, 32'(i));
            expect_v("brk_not_halted", K_HALTED, 0);
            cycle();
        end
        for (int i = 0; i < 20; i++) begin
            expect_v("halt_state", K_STATE, 19);
            expect_v("halt_halted", K_HALTED, 1);
            cycle();
        end
        Reset = 1'b1;
        expect_v("halt_rst_state", K_STATE, 0);
        expect_v("halt_rst_halted", K_HALTED, 0);
        cycle();
        Reset = 1'b0;

        // jalr: link, target computation, jump
        instruction = 32'h000080E7;
        for (int i = 0; i < 6; i++) begin
            expect_v("jalr_state", K_STATE, 32'(jr_st[i]));
            if (jr_st[i] == 15) begin
                expect_v("jalr_memtoreg", K_MEMTOREG, 3);
                expect_v("jalr_writereg", K_WRITEREG, 1);
            end
            if (jr_st[i] == 16) expect_v("jalr_loadaluout", K_LDALUOUT, 1);
            if (jr_st[i] == 17) begin
                expect_v("jalr_pcsrc", K_PCSRC, 1);
                expect_v("jalr_pcwrite", K_PCW, 1);
            end
            cycle();
        end

        // sw with data memory stalled, then Reset during MEM_WR
        instruction = 32'h0020A023;
        dmem_ready  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            expect_v("sw_state", K_STATE, 32'(st_st[i]));
            if (st_st[i] == 7) begin
                expect_v("sw_dmemwrite", K_DMEMWR, 1);
                expect_v("sw_dmem_req", K_DMEMREQ, 1);
                expect_v("sw_tam", K_TAM, 2);
            end
            cycle();
        end
        Reset = 1'b1;
        expect_v("sw_rst_state", K_STATE, 0);
        expect_v("sw_rst_dmemwrite", K_DMEMWR, 0);
        expect_v("sw_rst_dmem_req", K_DMEMREQ, 0);
        cycle();
        Reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
